// File: rtl/scratchpad_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port,
// registered-read scratchpad RAM. Range-checks requests, translates byte
// addresses and byte masks to RAM terms, and buffers responses per requester.

// Per-requester response FIFO with outputs taken straight from storage.
module scratchpad_arbiter_rsp_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SRC_W  = 8,
  parameter int unsigned DEPTH  = 3,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_write,
  input  logic              push_err,
  input  logic [DATA_W-1:0] push_rdata,
  input  logic [SRC_W-1:0]  push_source,
  output logic [CW-1:0]     count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [SRC_W-1:0]  rsp_source
);

  typedef struct packed {
    logic              write;
    logic              err;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign pop = rsp_valid & rsp_ready;

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; the empty count hides stale
  // entries and every output below is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{write: push_write, err: push_err,
                               source: push_source, rdata: push_rdata};
  end

  // Present the head entry, zeroed while empty.
  always_comb begin
    head       = mem[rd_ptr];
    rsp_valid  = (count != '0);
    rsp_write  = rsp_valid & head.write;
    rsp_err    = rsp_valid & head.err;
    rsp_source = rsp_valid ? head.source : '0;
    rsp_rdata  = rsp_valid ? head.rdata  : '0;
  end

endmodule

module scratchpad_arbiter #(
  parameter int unsigned          DATA_W    = 64,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          SRC_W     = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          DEPTH     = 32'h0000_0100,
  parameter int unsigned          RSP_DEPTH = 3,
  localparam int unsigned RAM_AW = $clog2(DEPTH / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_mask,
  input  logic [SRC_W-1:0]    req0_source,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_mask,
  input  logic [SRC_W-1:0]    req1_source,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp0_write,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp0_err,
  output logic [SRC_W-1:0]    rsp0_source,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic                rsp1_write,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                rsp1_err,
  output logic [SRC_W-1:0]    rsp1_source,
  output logic                ram_req,
  output logic                ram_write,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W-1:0]   ram_wmask,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned AW1 = ADDR_W + 1;
  // One past the last valid byte, widened so BASE_ADDR + DEPTH cannot wrap.
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + AW1'(DEPTH);

  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr < BASE_ADDR) || ({1'b0, addr} >= END_ADDR) || (addr[2:0] != 3'b000);
  endfunction

  logic [CW-1:0]       count0, count1;
  logic                inflight0, inflight1;
  logic                elig0, elig1;
  logic                grant0, grant1, grant_any;
  logic                rr_last;

  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_mask;
  logic [SRC_W-1:0]    sel_source;
  logic                sel_err;

  logic                p_valid, p_id, p_write, p_err;
  logic [SRC_W-1:0]    p_source;
  logic [DATA_W-1:0]   p_rdata;

  assign inflight0 = p_valid & ~p_id;
  assign inflight1 = p_valid &  p_id;

  // Eligibility reserves FIFO room for everything already accepted, then
  // round-robin picks one winner; nothing is granted while in reset.
  always_comb begin
    elig0 = ~rst & req0_valid & ((32'(count0) + 32'(inflight0)) < RSP_DEPTH);
    elig1 = ~rst & req1_valid & ((32'(count1) + 32'(inflight1)) < RSP_DEPTH);
    grant0    = elig0 & (~elig1 |  rr_last);
    grant1    = elig1 & (~elig0 | ~rr_last);
    grant_any = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Route the winner to the RAM port with address and mask translation.
  // NOTE: every output gets a default at the top of the block so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    sel_write  = grant1 ? req1_write  : req0_write;
    sel_addr   = grant1 ? req1_addr   : req0_addr;
    sel_wdata  = grant1 ? req1_wdata  : req0_wdata;
    sel_mask   = grant1 ? req1_mask   : req0_mask;
    sel_source = grant1 ? req1_source : req0_source;
    sel_err    = addr_err(sel_addr);

    ram_req   = grant_any & ~sel_err;
    ram_write = ram_req & sel_write;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (ram_req) begin
      ram_addr  = RAM_AW'((sel_addr - BASE_ADDR) >> 3);
      ram_wdata = sel_wdata;
      for (int i = 0; i < DATA_W / 8; i++) begin
        ram_wmask[i*8 +: 8] = {8{sel_mask[i] & sel_write}};
      end
    end
  end

  // Round-robin pointer remembers the last winner; requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_last <= 1'b1;
    else if (grant_any) rr_last <= grant1;
  end

  // Pipeline stage covering the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid  <= 1'b0;
      p_id     <= 1'b0;
      p_write  <= 1'b0;
      p_err    <= 1'b0;
      p_source <= '0;
    end else begin
      p_valid <= grant_any;
      if (grant_any) begin
        p_id     <= grant1;
        p_write  <= sel_write;
        p_err    <= sel_err;
        p_source <= sel_source;
      end
    end
  end

  // Only successful reads carry RAM data back.
  assign p_rdata = (!p_write && !p_err) ? ram_rdata : '0;

  scratchpad_arbiter_rsp_fifo #(
    .DATA_W (DATA_W),
    .SRC_W  (SRC_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp0_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (inflight0),
    .push_write  (p_write),
    .push_err    (p_err),
    .push_rdata  (p_rdata),
    .push_source (p_source),
    .count       (count0),
    .rsp_valid   (rsp0_valid),
    .rsp_ready   (rsp0_ready),
    .rsp_write   (rsp0_write),
    .rsp_rdata   (rsp0_rdata),
    .rsp_err     (rsp0_err),
    .rsp_source  (rsp0_source)
  );

  scratchpad_arbiter_rsp_fifo #(
    .DATA_W (DATA_W),
    .SRC_W  (SRC_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp1_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (inflight1),
    .push_write  (p_write),
    .push_err    (p_err),
    .push_rdata  (p_rdata),
    .push_source (p_source),
    .count       (count1),
    .rsp_valid   (rsp1_valid),
    .rsp_ready   (rsp1_ready),
    .rsp_write   (rsp1_write),
    .rsp_rdata   (rsp1_rdata),
    .rsp_err     (rsp1_err),
    .rsp_source  (rsp1_source)
  );

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Scoreboard bench for scratchpad_arbiter: stimulus pushes hand-computed
// expected responses, a negedge monitor pops and compares them.
module tb_scratchpad_arbiter;

  typedef struct {
    logic        write;
    logic        err;
    logic [7:0]  src;
    logic [63:0] rdata;
    int          gcyc;
    bit          exact;
  } exp_t;

  logic        clk, rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_mask  [2];
  logic [7:0]  req_source[2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_write [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [7:0]  rsp_source[2];
  logic        ram_req, ram_write;
  logic [4:0]  ram_addr;
  logic [63:0] ram_wdata, ram_wmask, ram_rdata;

  logic [63:0] ram_mem [32];
  int          cyc;
  int          n_checks, n_errors;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          grant_log[$];

  scratchpad_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_write(req_write[0]),
    .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]), .req0_mask(req_mask[0]),
    .req0_source(req_source[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_write(req_write[1]),
    .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]), .req1_mask(req_mask[1]),
    .req1_source(req_source[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_write(rsp_write[0]),
    .rsp0_rdata(rsp_rdata[0]), .rsp0_err(rsp_err[0]), .rsp0_source(rsp_source[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_write(rsp_write[1]),
    .rsp1_rdata(rsp_rdata[1]), .rsp1_err(rsp_err[1]), .rsp1_source(rsp_source[1]),
    .ram_req(ram_req), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read single-port RAM with bit-masked writes.
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Response monitor: pop the per-port scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check($sformatf("rsp%0d_unexpected", p), {56'd0, rsp_source[p]}, 64'hFFFF);
          end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rsp%0d_write", p),  {63'd0, rsp_write[p]}, {63'd0, e.write});
            check($sformatf("rsp%0d_err", p),    {63'd0, rsp_err[p]},   {63'd0, e.err});
            check($sformatf("rsp%0d_source", p), {56'd0, rsp_source[p]}, {56'd0, e.src});
            check($sformatf("rsp%0d_rdata", p),  rsp_rdata[p], e.rdata);
            if (e.exact) check($sformatf("rsp%0d_latency", p), 64'(cyc - e.gcyc), 64'd2);
          end
        end
      end
      if (req_ready[0] || req_ready[1]) begin
        check("single_grant", {63'd0, req_ready[0] & req_ready[1]}, 64'd0);
        grant_log.push_back(req_ready[1] ? 1 : 0);
      end
    end
  end

  // Issue one request, record its expected response at the grant cycle.
  task automatic send(input int p, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [7:0] mask, input logic [7:0] src,
                      input logic [63:0] exp_rdata, input logic exp_err, input bit exact);
    bit   granted = 0;
    exp_t e;
    req_valid[p] = 1'b1; req_write[p] = wr; req_addr[p] = addr;
    req_wdata[p] = wdata; req_mask[p] = mask; req_source[p] = src;
    for (int i = 0; i < 50 && !granted; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        granted = 1;
        e = '{write: wr, err: exp_err, src: src, rdata: exp_rdata, gcyc: cyc, exact: exact};
        if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        check("ram_req", {63'd0, ram_req}, {63'd0, !exp_err});
        check("ram_write", {63'd0, ram_write}, {63'd0, wr & !exp_err});
        if (!exp_err) check("ram_wmask", ram_wmask, wr ? expand(mask) : 64'd0);
      end
    end
    if (!granted) check($sformatf("grant_timeout_p%0d", p), 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(posedge clk);
    #1;
    check("drain_q0", 64'(exp_q0.size()), 64'd0);
    check("drain_q1", 64'(exp_q1.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t0;
    cyc = 0; n_checks = 0; n_errors = 0;
    for (int i = 0; i < 32; i++) ram_mem[i] = 64'd0;
    ram_rdata = 64'd0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_write[p] = 1'b0; req_addr[p] = 32'd0;
      req_wdata[p] = 64'd0; req_mask[p] = 8'd0; req_source[p] = 8'd0;
      rsp_ready[p] = 1'b1;
    end

    // Reset: a pending request must not leak through while rst is high.
    rst = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_wdata[0] = 64'hDEAD_BEEF_0BAD_F00D;
    req_mask[0] = 8'hFF; req_source[0] = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_req0_ready", {63'd0, req_ready[0]}, 64'd0);
    check("rst_rsp0_valid", {63'd0, rsp_valid[0]}, 64'd0);
    check("rst_rsp1_valid", {63'd0, rsp_valid[1]}, 64'd0);
    check("rst_ram_req",    {63'd0, ram_req}, 64'd0);
    check("rst_ram_write",  {63'd0, ram_write}, 64'd0);
    check("rst_ram_addr",   {59'd0, ram_addr}, 64'd0);
    check("rst_ram_wdata",  ram_wdata, 64'd0);
    check("rst_ram_wmask",  ram_wmask, 64'd0);
    check("rst_rsp0_rdata", rsp_rdata[0], 64'd0);
    check("rst_rsp0_source", {56'd0, rsp_source[0]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid[0] = 1'b0;

    // Single write then read-back, exact two-cycle latency.
    send(0, 1'b1, 32'h08, 64'h1122_3344_5566_7788, 8'hFF, 8'h01, 64'd0, 1'b0, 1);
    send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h02, 64'h1122_3344_5566_7788, 1'b0, 1);

    // Partial write through the byte mask.
    send(0, 1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h03, 64'd0, 1'b0, 1);
    send(0, 1'b1, 32'h10, 64'd0, 8'h0F, 8'h04, 64'd0, 1'b0, 1);
    send(0, 1'b0, 32'h10, 64'd0, 8'h00, 8'h05, 64'hFFFF_FFFF_0000_0000, 1'b0, 1);

    // Out-of-range read and misaligned write leave the RAM untouched.
    send(0, 1'b0, 32'h100, 64'd0, 8'h00, 8'h06, 64'd0, 1'b1, 1);
    send(0, 1'b1, 32'h0C, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 8'h07, 64'd0, 1'b1, 1);
    send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h08, 64'h1122_3344_5566_7788, 1'b0, 1);
    wait_drain();

    // Requester 1 write; leaves requester 0 next in line for a tie.
    send(1, 1'b1, 32'h20, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 8'h21, 64'd0, 1'b0, 1);
    wait_drain();

    // Contention: both stream four reads, grants alternate starting at 0.
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h30 + 8'(i), 64'h1122_3344_5566_7788, 1'b0, 1);
      for (int i = 0; i < 4; i++)
        send(1, 1'b0, 32'h20, 64'd0, 8'h00, 8'h40 + 8'(i), 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1);
    join
    check("contention_grants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("contention_order_%0d", i), 64'(grant_log[i]), 64'(i % 2));
    wait_drain();

    // Backpressure on requester 1: only three reads accepted.
    rsp_ready[1] = 1'b0;
    acc = 0;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h20; req_source[1] = 8'h50;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        exp_q1.push_back('{write: 1'b0, err: 1'b0, src: req_source[1],
                           rdata: 64'hA5A5_A5A5_5A5A_5A5A, gcyc: cyc, exact: 0});
        acc++;
      end
      @(posedge clk); #1;
      req_source[1] = 8'h50 + 8'(acc);
    end
    check("bp_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    check("bp_req1_ready", {63'd0, req_ready[1]}, 64'd0);
    @(posedge clk); #1;
    grant_log.delete();
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h58 + 8'(i), 64'h1122_3344_5566_7788, 1'b0, 1);
    check("bp_req0_cycles", 64'(cyc - t0), 64'd4);
    check("bp_req0_grants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size(); i++)
      check($sformatf("bp_grant_%0d", i), 64'(grant_log[i]), 64'd0);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    wait_drain();

    // Reset with two responses queued and one in flight.
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h60 + 8'(i), 64'h1122_3344_5566_7788, 1'b0, 0);
    check("pre_rst_rsp0_valid", {63'd0, rsp_valid[0]}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rsp0_valid", {63'd0, rsp_valid[0]}, 64'd0);
    check("async_rst_rsp1_valid", {63'd0, rsp_valid[1]}, 64'd0);
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    grant_log.delete();
    rst = 1'b0;
    #1;
    check("post_rst_rsp0_valid", {63'd0, rsp_valid[0]}, 64'd0);
    check("post_rst_rsp1_valid", {63'd0, rsp_valid[1]}, 64'd0);
    fork
      send(0, 1'b0, 32'h08, 64'd0, 8'h00, 8'h70, 64'h1122_3344_5566_7788, 1'b0, 1);
      send(1, 1'b0, 32'h20, 64'd0, 8'h00, 8'h71, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1);
    join
    check("post_rst_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check("post_rst_first_grant", 64'(grant_log[0]), 64'd0);
      check("post_rst_second_grant", 64'(grant_log[1]), 64'd1);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
